tcp_vlg_tx_seg_mc: RTL and testbench

Multi-channel TCP transmit segmenter for the vlg TCP engine. It accepts up to N independent raw byte streams, one per connection. Each stream is cut into segments bounded by MSS, an idle timeout, or a user flush. Completed segment descriptors (channel, start sequence, length, payload checksum) go to one shared descriptor port under round-robin arbitration. It generalises the single-connection add stage to N channels, adds an in-line payload checksum, and adds descriptor-port backpressure.

---
 rtl/tcp_vlg_tx_seg_mc_if.sv | 28 ++
 rtl/tcp_vlg_tx_seg_mc.sv | 174 +++++++++++++++++
 tb/tb_tcp_vlg_tx_seg_mc.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_vlg_tx_seg_mc_if.sv
// rtl/tcp_vlg_tx_seg_mc_if.sv - per-channel byte streams and shared descriptor port
interface tcp_vlg_tx_seg_mc_if #(
  parameter int N  = 4,
  parameter int CW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    ch_rst;
  logic [N-1:0]    val;
  logic [N*8-1:0]  dat;
  logic [N*32-1:0] seq;
  logic [N-1:0]    flush;
  logic [N-1:0]    cts;
  logic            pkt_val;
  logic            pkt_rdy;
  logic [CW-1:0]   pkt_ch;
  logic [31:0]     pkt_start;
  logic [15:0]     pkt_len;
  logic [15:0]     pkt_cks;

  modport slave (
    input  ch_rst, val, dat, seq, flush, pkt_rdy,
    output cts, pkt_val, pkt_ch, pkt_start, pkt_len, pkt_cks
  );

  modport master (
    output ch_rst, val, dat, seq, flush, pkt_rdy,
    input  cts, pkt_val, pkt_ch, pkt_start, pkt_len, pkt_cks
  );
endinterface

// File: rtl/tcp_vlg_tx_seg_mc.sv
// rtl/tcp_vlg_tx_seg_mc.sv - multi-channel TCP tx segmenter with payload checksum
// Each channel cuts its byte stream into segments; a round-robin arbiter emits descriptors.
module tcp_vlg_tx_seg_mc #(
  parameter int N          = 4,
  parameter int MTU        = 1500,
  parameter int WAIT_TICKS = 20
) (
  input  logic               clk,
  input  logic               rst,
  tcp_vlg_tx_seg_mc_if.slave bus
);
  localparam int              CW     = (N > 1) ? $clog2(N) : 1;
  localparam int              TW     = $clog2(WAIT_TICKS + 1);
  localparam logic [15:0]     MSS    = 16'(MTU - 40);
  localparam logic [TW-1:0]   WAIT_L = TW'(WAIT_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_PEND} state_e;

  state_e        state_q [N];
  state_e        state_d [N];
  logic [31:0]   start_q [N];
  logic [31:0]   start_d [N];
  logic [15:0]   len_q   [N];
  logic [15:0]   len_d   [N];
  logic [15:0]   cks_q   [N];
  logic [15:0]   cks_d   [N];
  logic [TW-1:0] timer_q [N];
  logic [TW-1:0] timer_d [N];

  logic [CW-1:0] rr_q, rr_d;
  logic          pkt_val_q, pkt_val_d;
  logic [CW-1:0] pkt_ch_q, pkt_ch_d;
  logic [31:0]   pkt_start_q, pkt_start_d;
  logic [15:0]   pkt_len_q, pkt_len_d;
  logic [15:0]   pkt_cks_q, pkt_cks_d;

  logic          hs;
  logic [N-1:0]  cand;
  logic [CW-1:0] nxt;
  logic [CW-1:0] search;
  logic [CW-1:0] idx;
  logic [CW-1:0] sel;
  logic          found;
  logic [N-1:0]  cts_w;

  // Even-offset bytes land in the high half; end-around carry folds back in.
  function automatic logic [15:0] cks_add(input logic [15:0] s, input logic [7:0] b,
                                          input logic odd);
    logic [16:0] sum;
    sum = {1'b0, s} + {1'b0, (odd ? {8'h00, b} : {b, 8'h00})};
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  assign hs = pkt_val_q && bus.pkt_rdy;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      start_d[i] = start_q[i];
      len_d[i]   = len_q[i];
      cks_d[i]   = cks_q[i];
      timer_d[i] = timer_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (bus.val[i]) begin
            state_d[i] = (bus.flush[i] || MSS == 16'd1) ? S_PEND : S_ACC;
            start_d[i] = bus.seq[i*32 +: 32];
            len_d[i]   = 16'd1;
            cks_d[i]   = {bus.dat[i*8 +: 8], 8'h00};
            timer_d[i] = '0;
          end
        end
        S_ACC: begin
          if (bus.val[i]) begin
            len_d[i]   = len_q[i] + 16'd1;
            cks_d[i]   = cks_add(cks_q[i], bus.dat[i*8 +: 8], len_q[i][0]);
            timer_d[i] = '0;
            if (bus.flush[i] || (len_q[i] + 16'd1) == MSS) state_d[i] = S_PEND;
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
            if (bus.flush[i] || (timer_q[i] + 1'b1) == WAIT_L) state_d[i] = S_PEND;
          end
        end
        S_PEND: begin
          if (hs && pkt_ch_q == CW'(i)) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
      if (bus.ch_rst[i]) begin
        state_d[i] = S_IDLE;
        len_d[i]   = '0;
        cks_d[i]   = '0;
        timer_d[i] = '0;
      end
      cts_w[i] = (state_q[i] != S_PEND);
    end
  end

  // A channel being granted or cleared this cycle is not eligible for the next slot.
  always_comb begin
    nxt    = (int'(pkt_ch_q) == N - 1) ? '0 : pkt_ch_q + 1'b1;
    search = hs ? nxt : rr_q;
    rr_d   = hs ? nxt : rr_q;
    for (int i = 0; i < N; i++) begin
      cand[i] = (state_q[i] == S_PEND) && !bus.ch_rst[i] && !(hs && pkt_ch_q == CW'(i));
    end
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = CW'((int'(search) + k) % N);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    pkt_val_d   = pkt_val_q;
    pkt_ch_d    = pkt_ch_q;
    pkt_start_d = pkt_start_q;
    pkt_len_d   = pkt_len_q;
    pkt_cks_d   = pkt_cks_q;
    if (!pkt_val_q || hs) begin
      pkt_val_d = found;
      if (found) begin
        pkt_ch_d    = sel;
        pkt_start_d = start_q[sel];
        pkt_len_d   = len_q[sel];
        pkt_cks_d   = cks_q[sel];
      end
    end else if (bus.ch_rst[pkt_ch_q]) begin
      pkt_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= S_IDLE;
        start_q[i] <= '0;
        len_q[i]   <= '0;
        cks_q[i]   <= '0;
        timer_q[i] <= '0;
      end
      rr_q        <= '0;
      pkt_val_q   <= 1'b0;
      pkt_ch_q    <= '0;
      pkt_start_q <= '0;
      pkt_len_q   <= '0;
      pkt_cks_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        start_q[i] <= start_d[i];
        len_q[i]   <= len_d[i];
        cks_q[i]   <= cks_d[i];
        timer_q[i] <= timer_d[i];
      end
      rr_q        <= rr_d;
      pkt_val_q   <= pkt_val_d;
      pkt_ch_q    <= pkt_ch_d;
      pkt_start_q <= pkt_start_d;
      pkt_len_q   <= pkt_len_d;
      pkt_cks_q   <= pkt_cks_d;
    end
  end

  assign bus.cts       = cts_w;
  assign bus.pkt_val   = pkt_val_q;
  assign bus.pkt_ch    = pkt_ch_q;
  assign bus.pkt_start = pkt_start_q;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.pkt_cks   = pkt_cks_q;
endmodule

// File: tb/tb_tcp_vlg_tx_seg_mc.sv
// tb/tb_tcp_vlg_tx_seg_mc.sv - directed self-checking bench for tcp_vlg_tx_seg_mc
module tb_tcp_vlg_tx_seg_mc;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   failures;

  always #5 clk = ~clk;

  tcp_vlg_tx_seg_mc_if #(.N(N)) bus ();

  tcp_vlg_tx_seg_mc #(.N(N), .MTU(1500), .WAIT_TICKS(20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [7:0] b, input logic [31:0] s);
    bus.dat[ch*8 +: 8]  = b;
    bus.seq[ch*32 +: 32] = s;
  endtask

  task automatic expect_desc(input string tag, input int ch, input logic [31:0] start,
                             input logic [15:0] len, input logic [15:0] cks);
    check({tag, "_val"},   96'(bus.pkt_val),   96'(1));
    check({tag, "_ch"},    96'(bus.pkt_ch),    96'(ch));
    check({tag, "_start"}, 96'(bus.pkt_start), 96'(start));
    check({tag, "_len"},   96'(bus.pkt_len),   96'(len));
    check({tag, "_cks"},   96'(bus.pkt_cks),   96'(cks));
  endtask

  function automatic logic [15:0] ref_cks(input logic [7:0] q[$]);
    logic [31:0] s;
    s = 32'd0;
    foreach (q[k]) s += (k % 2 == 0) ? {16'h0, q[k], 8'h00} : {24'h0, q[k]};
    while (s[31:16] != 16'd0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic four_flush(input string tag, input int first);
    for (int i = 0; i < N; i++) put(i, 8'h10 + 8'(i), 32'h100 * i);
    bus.val = 4'hF;
    bus.flush = 4'hF;
    tick();
    bus.val = '0;
    bus.flush = '0;
    bus.pkt_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      check({tag, "_ch"},  96'(bus.pkt_ch),  96'((first + i) % N));
      check({tag, "_cks"}, 96'(bus.pkt_cks), 96'({8'h10 + 8'((first + i) % N), 8'h00}));
    end
    tick();
    check({tag, "_drain"}, 96'(bus.pkt_val), 96'(0));
  endtask

  logic [7:0]  fold_bytes [5];
  logic [7:0]  mss_q [$];
  logic [31:0] base;
  int          seen;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.ch_rst = '0;
    bus.val = '0;
    bus.flush = '0;
    bus.dat = '0;
    bus.seq = '0;
    bus.pkt_rdy = 1'b0;
    tick();
    tick();
    check("rst_cts",   96'(bus.cts),       96'(4'hF));
    check("rst_val",   96'(bus.pkt_val),   96'(0));
    check("rst_ch",    96'(bus.pkt_ch),    96'(0));
    check("rst_start", 96'(bus.pkt_start), 96'(0));
    check("rst_len",   96'(bus.pkt_len),   96'(0));
    check("rst_cks",   96'(bus.pkt_cks),   96'(0));
    rst = 1'b0;

    // Idle timeout on channel 0
    put(0, 8'h01, 32'hFFFF_FFFE);
    bus.val[0] = 1'b1;
    tick();
    put(0, 8'h02, 32'hFFFF_FFFF);
    tick();
    put(0, 8'h03, 32'h0000_0000);
    tick();
    bus.val[0] = 1'b0;
    repeat (19) tick();
    check("t1_cts_before_timeout", 96'(bus.cts[0]), 96'(1));
    tick();
    check("t1_cts_pend", 96'(bus.cts[0]), 96'(0));
    check("t1_val_early", 96'(bus.pkt_val), 96'(0));
    tick();
    expect_desc("t1", 0, 32'hFFFF_FFFE, 16'd3, 16'h0402);
    bus.pkt_rdy = 1'b1;
    tick();
    bus.pkt_rdy = 1'b0;
    check("t1_val_after_hs", 96'(bus.pkt_val), 96'(0));
    check("t1_cts_after_hs", 96'(bus.cts[0]), 96'(1));

    // Flush with no byte while idle does nothing
    bus.flush[0] = 1'b1;
    tick();
    bus.flush[0] = 1'b0;
    check("noop_cts", 96'(bus.cts[0]), 96'(1));
    tick();
    check("noop_val", 96'(bus.pkt_val), 96'(0));

    // End-around carry on channel 2, flush with last byte
    fold_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    for (int k = 0; k < 5; k++) begin
      put(2, fold_bytes[k], 32'h0000_1000 + 32'(k));
      bus.val[2] = 1'b1;
      bus.flush[2] = (k == 4);
      tick();
    end
    bus.val = '0;
    bus.flush = '0;
    check("fold_cts", 96'(bus.cts[2]), 96'(0));
    tick();
    expect_desc("fold", 2, 32'h0000_1000, 16'd5, 16'h0100);
    bus.pkt_rdy = 1'b1;
    tick();
    bus.pkt_rdy = 1'b0;

    // Round-robin from rr=0, then from rr=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    four_flush("rr0", 0);
    put(1, 8'h55, 32'h0);
    bus.val[1] = 1'b1;
    bus.flush[1] = 1'b1;
    tick();
    bus.val = '0;
    bus.flush = '0;
    tick();
    tick();
    check("rr_bump_ch", 96'(bus.pkt_ch), 96'(1));
    tick();
    four_flush("rr2", 2);

    // Hold under backpressure, then clear the presented channel
    bus.pkt_rdy = 1'b0;
    put(0, 8'hA0, 32'h0000_A000);
    put(3, 8'hA3, 32'h0000_A300);
    bus.val = 4'b1001;
    bus.flush = 4'b1001;
    tick();
    bus.val = '0;
    bus.flush = '0;
    tick();
    expect_desc("hold0", 3, 32'h0000_A300, 16'd1, 16'hA300);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_stable",
            96'({bus.pkt_val, bus.pkt_ch, bus.pkt_start, bus.pkt_len, bus.pkt_cks}),
            96'({1'b1, 2'd3, 32'h0000_A300, 16'd1, 16'hA300}));
    end
    bus.ch_rst[3] = 1'b1;
    tick();
    bus.ch_rst = '0;
    check("chrst_val", 96'(bus.pkt_val), 96'(0));
    check("chrst_cts", 96'(bus.cts[3]), 96'(1));
    tick();
    expect_desc("chrst_next", 0, 32'h0000_A000, 16'd1, 16'hA000);
    bus.pkt_rdy = 1'b1;
    tick();
    bus.pkt_rdy = 1'b0;
    check("chrst_drain", 96'(bus.pkt_val), 96'(0));

    // MSS close on channel 1, extra byte held back then resent
    base = 32'h5000_0000;
    bus.val[1] = 1'b1;
    for (int k = 0; k < 1460; k++) begin
      put(1, k[7:0], base + 32'(k));
      mss_q.push_back(k[7:0]);
      tick();
    end
    check("mss_cts_low1", 96'(bus.cts[1]), 96'(0));
    put(1, 8'hEE, base + 32'd1460);
    tick();
    check("mss_cts_low2", 96'(bus.cts[1]), 96'(0));
    expect_desc("mss", 1, base, 16'd1460, ref_cks(mss_q));
    bus.pkt_rdy = 1'b1;
    tick();
    bus.pkt_rdy = 1'b0;
    check("mss_cts_back", 96'(bus.cts[1]), 96'(1));
    bus.flush[1] = 1'b1;
    tick();
    bus.val = '0;
    bus.flush = '0;
    check("mss_next_pend", 96'(bus.cts[1]), 96'(0));
    tick();
    expect_desc("mss_next", 1, base + 32'd1460, 16'd1, 16'hEE00);
    bus.pkt_rdy = 1'b1;
    tick();
    bus.pkt_rdy = 1'b0;

    // Reset with two channels accumulating and one pending/presented
    put(0, 8'h11, 32'h1);
    put(1, 8'h22, 32'h2);
    put(2, 8'h33, 32'h3);
    bus.val = 4'b0111;
    bus.flush = 4'b0100;
    tick();
    bus.val = '0;
    bus.flush = '0;
    check("mid_cts", 96'(bus.cts), 96'(4'b1011));
    tick();
    check("mid_presented", 96'(bus.pkt_val), 96'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cts",   96'(bus.cts),       96'(4'hF));
    check("mid_rst_val",   96'(bus.pkt_val),   96'(0));
    check("mid_rst_ch",    96'(bus.pkt_ch),    96'(0));
    check("mid_rst_start", 96'(bus.pkt_start), 96'(0));
    check("mid_rst_len",   96'(bus.pkt_len),   96'(0));
    check("mid_rst_cks",   96'(bus.pkt_cks),   96'(0));
    seen = 0;
    repeat (30) begin
      tick();
      if (bus.pkt_val) seen++;
    end
    check("post_rst_quiet", 96'(seen), 96'(0));
    check("post_rst_cts", 96'(bus.cts), 96'(4'hF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
